instruction_fetch: RTL and testbench

IF stage of the MIPS core, directly upstream of the decoder. Holds the PC and issues one word request at a time to instruction memory. Presents the returned 32-bit instruction and its PC to decode through a valid/ready output register. Takes redirects from later stages: branch or jump target.

---
 rtl/mips_pkg.sv | 17 +
 rtl/instruction_fetch.sv | 167 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the fetch stage: opcodes, fetch states
// and the default reset vector.
package mips_pkg;

    localparam logic [5:0]  OPC_J            = 6'h02;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

    function automatic logic is_jump(input logic [31:0] word);
        return (word[31:26] == OPC_J);
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// MIPS IF stage: one outstanding word fetch, valid/ready output register to decode,
// redirect flush. Optional j predecode when FETCH_JUMP_PREDECODE_EN is defined.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    fetch_state_e      state_r, state_n_s;
    logic [ADDR_W-1:0] pc_r, pc_n_s;
    logic              kill_r, kill_n_s;
    logic              valid_r, valid_n_s;
    logic [31:0]       instr_r, instr_n_s;
    logic [ADDR_W-1:0] pc_out_r, pc_out_n_s;
    logic [ADDR_W-1:0] pc_plus4_r, pc_plus4_n_s;
    logic              req_s;
    logic              load_s;
    logic              consume_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] redirect_aligned_s;
    logic              unused_redirect_lsb_s;
`ifdef FETCH_JUMP_PREDECODE_EN
    logic [ADDR_W-1:0] jump_target_s;
`endif

    assign pc_inc_s              = pc_r + PC_STEP;
    assign redirect_aligned_s    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb_s = ^redirect_pc[1:0];
`ifdef FETCH_JUMP_PREDECODE_EN
    assign jump_target_s = {pc_inc_s[ADDR_W-1:28], imem_rdata[25:0], 2'b00};
`endif

    // Request issue: only from FETCH, with the output slot free or draining this cycle.
    always_comb begin
        req_s = 1'b0;
        if (state_r == FETCH) begin
            req_s = !redirect_valid && (!valid_r || instr_ready);
        end else begin
            req_s = 1'b0;
        end
    end

    assign imem_req  = req_s && rst_n;
    assign imem_addr = pc_r;

    // Next-state, PC, kill flag and output-register update; redirect overrides everything.
    always_comb begin
        state_n_s    = state_r;
        pc_n_s       = pc_r;
        kill_n_s     = kill_r;
        valid_n_s    = valid_r;
        instr_n_s    = instr_r;
        pc_out_n_s   = pc_out_r;
        pc_plus4_n_s = pc_plus4_r;
        load_s       = 1'b0;
        consume_s    = valid_r && instr_ready;

        if (redirect_valid) begin
            pc_n_s    = redirect_aligned_s;
            valid_n_s = 1'b0;
            if ((state_r == WAIT) && !imem_rvalid) begin
                kill_n_s  = 1'b1;
                state_n_s = WAIT;
            end else begin
                // A response landing with the redirect is simply dropped.
                kill_n_s  = 1'b0;
                state_n_s = FETCH;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (req_s) begin
                        state_n_s = WAIT;
                    end else begin
                        state_n_s = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_n_s = FETCH;
                        if (kill_r) begin
                            kill_n_s = 1'b0;
                        end else begin
                            load_s       = 1'b1;
                            instr_n_s    = imem_rdata;
                            pc_out_n_s   = pc_r;
                            pc_plus4_n_s = pc_inc_s;
                            valid_n_s    = 1'b1;
`ifdef FETCH_JUMP_PREDECODE_EN
                            if (is_jump(imem_rdata)) begin
                                pc_n_s = jump_target_s;
                            end else begin
                                pc_n_s = pc_inc_s;
                            end
`else
                            pc_n_s = pc_inc_s;
`endif
                        end
                    end else begin
                        state_n_s = WAIT;
                    end
                end
                default: begin
                    state_n_s = FETCH;
                    kill_n_s  = 1'b0;
                end
            endcase

            if (consume_s && !load_s) begin
                valid_n_s = 1'b0;
            end else begin
                valid_n_s = valid_n_s;
            end
        end
    end

    // Fetch control registers: state, PC and kill flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            pc_r    <= pc_n_s;
            kill_r  <= kill_n_s;
        end
    end

    // Output register toward decode; payload holds while valid and not accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            instr_r    <= 32'h0000_0000;
            pc_out_r   <= {ADDR_W{1'b0}};
            pc_plus4_r <= {ADDR_W{1'b0}};
        end else begin
            valid_r    <= valid_n_s;
            instr_r    <= instr_n_s;
            pc_out_r   <= pc_out_n_s;
            pc_plus4_r <= pc_plus4_n_s;
        end
    end

    assign instr_valid = valid_r;
    assign instruction = instr_r;
    assign pc_out      = pc_out_r;
    assign pc_plus4    = pc_plus4_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, reset-in-WAIT
// sequence, then randomized traffic against a transaction-level reference model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;

`ifdef FETCH_JUMP_PREDECODE_EN
    localparam bit          JMP_EN   = 1'b1;
    localparam logic [31:0] JMP_NEXT = 32'h1000_0040;
`else
    localparam bit          JMP_EN   = 1'b0;
    localparam logic [31:0] JMP_NEXT = 32'h1000_0004;
`endif

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] einstr;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ready, input logic redir, input logic [31:0] rpc,
                       input logic rvalid, input logic [31:0] rdata,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, input logic [31:0] einstr, input logic [31:0] epc);
        vec_t v;
        v.ready = ready;   v.redir = redir;   v.rpc = rpc;
        v.rvalid = rvalid; v.rdata = rdata;
        v.ereq = ereq;     v.eaddr = eaddr;
        v.evalid = evalid; v.einstr = einstr; v.epc = epc;
        vecs.push_back(v);
    endtask

    // Program image seen by the random phase memory.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2008_0005;
        if (a == 32'h1000_0000) return 32'h0800_0010;
        return {6'h23, a[27:2]};
    endfunction

    // Address of the instruction that follows word w fetched from p.
    function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [31:0] w, input bit en);
        if (en && (w[31:26] == 6'h02))
            return ((p + 32'd4) & 32'hF000_0000) | ({6'd0, w[25:0]} << 2);
        return p + 32'd4;
    endfunction

    // reference model state
    logic [31:0] m_pc, m_opc;
    bit          m_valid, m_out, m_stale, exp_req;
    // memory responder state
    bit          mb;
    int          mc;
    logic [31:0] ma;

    initial begin
        rst_n = 1'b0;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;

        //    rdy red rpc            rv rdata          req addr             vld instr          pc
        add(1, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          1, 32'h2008_0005,  0, 32'h0,          0, 32'h0,          32'h0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 32'h0,      0, 32'h0,          0, 32'h0,          1, 32'h2008_0005,  32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          1, 32'h4,          1, 32'h2008_0005,  32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 1, 32'h0000_0103,  0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          1, 32'hDEAD_BEEF,  0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          1, 32'h100,        0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          1, 32'h1111_2222,  0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          1, 32'h104,        1, 32'h1111_2222,  32'h100);
        add(1, 1, 32'hFFFF_FFFE,  1, 32'h0BAD_F00D,  0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          1, 32'h3333_4444,  0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          1, 32'h0,          1, 32'h3333_4444,  32'hFFFF_FFFC);
        add(1, 1, 32'h1000_0000,  1, 32'h0000_0005,  0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          1, 32'h1000_0000,  0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          1, 32'h0800_0010,  0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          1, JMP_NEXT,       1, 32'h0800_0010,  32'h1000_0000);
        add(1, 0, 32'h0,          1, 32'h0000_0000,  0, 32'h0,          0, 32'h0,          32'h0);
        add(1, 0, 32'h0,          0, 32'h0,          1, JMP_NEXT + 32'd4, 1, 32'h0,        JMP_NEXT);

        // reset state, with decode ready so an ungated request would show
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            instr_ready    = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            imem_rvalid    = vecs[i].rvalid;
            imem_rdata     = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].ereq});
            if (vecs[i].ereq) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].eaddr);
            chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].evalid});
            if (vecs[i].evalid) begin
                chk($sformatf("vec%0d_instr", i), instruction, vecs[i].einstr);
                chk($sformatf("vec%0d_pc_out", i), pc_out, vecs[i].epc);
                chk($sformatf("vec%0d_pc_plus4", i), pc_plus4, vecs[i].epc + 32'd4);
            end
            @(negedge clk);
        end

        // reset while a request is outstanding: request gated, outputs cleared
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        imem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("wait_rst_req", {31'd0, imem_req}, 32'd0);
        chk("wait_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("wait_rst_instr", instruction, 32'h0);
        chk("wait_rst_pc_out", pc_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        m_pc = 32'h0; m_opc = 32'h0;
        m_valid = 0; m_out = 0; m_stale = 0;
        mb = 0; mc = 0; ma = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            imem_rvalid    = mb && (mc == 0);
            imem_rdata     = imem_rvalid ? mem_word(ma) : $urandom;
            #1;
            exp_req = !m_out && !redirect_valid && (!m_valid || instr_ready);
            chk("rnd_req", {31'd0, imem_req}, {31'd0, exp_req});
            if (exp_req) chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("rnd_instr", instruction, mem_word(m_opc));
                chk("rnd_pc_out", pc_out, m_opc);
                chk("rnd_pc_plus4", pc_plus4, m_opc + 32'd4);
            end

            if (redirect_valid) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_valid = 0;
                if (m_out) begin
                    if (imem_rvalid) begin
                        m_out = 0;
                        m_stale = 0;
                    end else begin
                        m_stale = 1;
                    end
                end
            end else if (imem_rvalid && m_out) begin
                m_out = 0;
                if (m_stale) begin
                    m_stale = 0;
                    if (m_valid && instr_ready) m_valid = 0;
                end else begin
                    m_valid = 1;
                    m_opc = m_pc;
                    m_pc = next_pc(m_pc, mem_word(m_pc), JMP_EN);
                end
            end else begin
                if (m_valid && instr_ready) m_valid = 0;
                if (exp_req) m_out = 1;
            end

            if (imem_rvalid) mb = 0;
            else if (mb) mc--;
            if (imem_req) begin
                mb = 1;
                mc = $urandom_range(0, 3);
                ma = imem_addr;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
